// File: rtl/testport_pkg.sv
// rtl/testport_pkg.sv - shared constants and state encodings for the test port writer
//
// Purpose : Bus widths, FSM state encodings and the default test-port
//           address/symbols shared between the writer and the TestBed checker.
// Ports   : none (package).

package testport_pkg;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;

   // Defaults shared with the TestBed checker
   localparam logic [ADDR_W-1:0] TP_TEST_PORT = 30'hFF;
   localparam logic [DATA_W-1:0] TP_BEGIN_SYM = 32'h0000_0168;
   localparam logic [DATA_W-1:0] TP_END_SYM   = 32'h0000_0D5D;

   // FSM state encodings (kept as plain constants for legacy compatibility)
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_BEG  = 3'd1;
   localparam logic [2:0] ST_GAP  = 3'd2;
   localparam logic [2:0] ST_DAT  = 3'd3;
   localparam logic [2:0] ST_END  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/testport_writer_if.sv
// rtl/testport_writer_if.sv - result-stream and memory-write bundle of the test port writer
//
// Purpose : Groups the result-word handshake and the memory write bus.
// Signals : res_valid/res_data/res_ready - result words into the writer
//           mem_addr/mem_wdata/mem_wen     - write bus out of the writer
//           mem_stall                      - bus/D-cache stall into the writer
// Modports: master - the writer; slave - datapath/bus side.

interface testport_writer_if;
   import testport_pkg::*;

   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              res_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wen;
   logic              mem_stall;

   modport master (
      input  res_valid, res_data, mem_stall,
      output res_ready, mem_addr, mem_wdata, mem_wen
   );

   modport slave (
      output res_valid, res_data, mem_stall,
      input  res_ready, mem_addr, mem_wdata, mem_wen
   );

endinterface

// File: rtl/testport_fifo.sv
// rtl/testport_fifo.sv - synchronous result-word FIFO for the test port writer
//
// Purpose : DEPTH-entry 32-bit FIFO with registered full/empty flags.
// Ports   : clk, rst (async active-low)
//           push, din  - write side (ignored while full)
//           pop, dout  - read side, dout shows the head entry
//           full, empty - registered status flags

module testport_fifo
   import testport_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW:0]       count;
   logic [PW:0]       count_nxt;
   logic              do_push;
   logic              do_pop;

   // A push while full is refused even if a pop happens in the same cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      count_nxt = count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         full  <= (count_nxt == CNT_MAX);
         empty <= (count_nxt == '0);
      end
   end

   // Storage needs no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/testport_writer.sv
// rtl/testport_writer.sv - frames buffered result words as writes to the test port
//
// Purpose : Buffers result words and emits BEGIN_SYM, NUM_RESULTS data words and
//           END_SYM as single-pulse memory writes, with one wen=0 cycle after
//           every accepted write. Honours mem_stall.
// Ports   : clk, rst (async active-low)
//           start    - one-cycle pulse, begins a frame from IDLE/DONE
//           bus      - testport_writer_if.master (result stream + write bus)
//           busy     - frame in progress
//           done     - frame complete, held until next start or reset
//           sent_cnt - data words accepted by the bus in this frame

module testport_writer
   import testport_pkg::*;
#(
   parameter logic [ADDR_W-1:0] TEST_PORT   = TP_TEST_PORT,
   parameter logic [DATA_W-1:0] BEGIN_SYM   = TP_BEGIN_SYM,
   parameter logic [DATA_W-1:0] END_SYM     = TP_END_SYM,
   parameter int                NUM_RESULTS = 2,
   parameter int                FIFO_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   testport_writer_if.master   bus,
   output logic                busy,
   output logic                done,
   output logic [7:0]          sent_cnt
);

   localparam logic [7:0] NUM_C = 8'(NUM_RESULTS);

   logic [2:0]        state;
   logic              end_sent;   // the current GAP follows the END write
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wen_q;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              accept;

   assign accept   = wen_q & ~bus.mem_stall;
   assign fifo_pop = accept & (state == ST_DAT);

   testport_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.res_valid),
      .pop   (fifo_pop),
      .din   (bus.res_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.res_ready = ~fifo_full;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wen   = wen_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         end_sent <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wen_q    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sent_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_BEG;
                  end_sent <= 1'b0;
                  wen_q    <= 1'b1;
                  addr_q   <= TEST_PORT;
                  wdata_q  <= BEGIN_SYM;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  sent_cnt <= '0;
               end
            end

            ST_BEG, ST_END: begin
               // While stalled the write is simply held as is.
               if (accept) begin
                  state    <= ST_GAP;
                  end_sent <= (state == ST_END);
                  wen_q    <= 1'b0;
                  addr_q   <= '0;
                  wdata_q  <= '0;
               end
            end

            ST_DAT: begin
               if (wen_q) begin
                  if (!bus.mem_stall) begin
                     state   <= ST_GAP;
                     wen_q   <= 1'b0;
                     addr_q  <= '0;
                     wdata_q <= '0;
                     if (sent_cnt < NUM_C) sent_cnt <= sent_cnt + 8'd1;
                  end
               end else if (!fifo_empty) begin
                  // Entered with an empty FIFO: launch once a word shows up.
                  wen_q   <= 1'b1;
                  addr_q  <= TEST_PORT;
                  wdata_q <= fifo_dout;
               end
            end

            ST_GAP: begin
               if (end_sent) begin
                  state    <= ST_DONE;
                  end_sent <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else if (sent_cnt < NUM_C) begin
                  state <= ST_DAT;
                  if (!fifo_empty) begin
                     wen_q   <= 1'b1;
                     addr_q  <= TEST_PORT;
                     wdata_q <= fifo_dout;
                  end
               end else begin
                  state   <= ST_END;
                  wen_q   <= 1'b1;
                  addr_q  <= TEST_PORT;
                  wdata_q <= END_SYM;
               end
            end

            default: begin
               state    <= ST_IDLE;
               end_sent <= 1'b0;
               wen_q    <= 1'b0;
               addr_q   <= '0;
               wdata_q  <= '0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_testport_writer.sv
// tb/tb_testport_writer.sv - self-checking bench for testport_writer

module tb_testport_writer;

   localparam int N     = 2;
   localparam int DEPTH = 4;
   localparam logic [29:0] TP   = 30'hFF;
   localparam logic [31:0] BSYM = 32'h0000_0168;
   localparam logic [31:0] ESYM = 32'h0000_0D5D;
   localparam int K_BEG = 0;
   localparam int K_DAT = 1;
   localparam int K_END = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] sent_cnt;

   testport_writer_if bus();

   testport_writer #(
      .NUM_RESULTS (N),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus.master),
      .busy     (busy),
      .done     (done),
      .sent_cnt (sent_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int first_wen_cyc = -1;
   int done_cyc = -1;
   bit chk_en = 1'b0;
   logic [31:0] acc_q [$];

   // Behavioural model: FIFO as a queue, frame as a list of pending writes.
   logic [31:0] mq [$];
   int          plan [$];
   bit          m_active, m_done, m_gap, m_wen;
   logic [29:0] m_addr;
   logic [31:0] m_data;
   int          m_sent;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      plan.delete();
      m_active = 0; m_done = 0; m_gap = 0; m_wen = 0;
      m_addr = '0; m_data = '0; m_sent = 0;
   endtask

   task automatic model_issue();
      if (plan[0] == K_DAT && mq.size() == 0) return;
      m_wen  = 1;
      m_addr = TP;
      m_data = (plan[0] == K_BEG) ? BSYM : (plan[0] == K_END) ? ESYM : mq[0];
   endtask

   task automatic model_step();
      bit          push_ok;
      logic [31:0] pushed;
      push_ok = bus.res_valid && (mq.size() < DEPTH);
      pushed  = bus.res_data;
      if (m_wen) begin
         if (!bus.mem_stall) begin
            if (plan[0] == K_DAT) begin
               void'(mq.pop_front());
               if (m_sent < N) m_sent++;
            end
            void'(plan.pop_front());
            m_wen = 0; m_addr = '0; m_data = '0; m_gap = 1;
         end
      end else if (!m_active) begin
         if (start) begin
            plan.delete();
            plan.push_back(K_BEG);
            for (int i = 0; i < N; i++) plan.push_back(K_DAT);
            plan.push_back(K_END);
            m_active = 1; m_done = 0; m_sent = 0;
            model_issue();
         end
      end else if (m_gap) begin
         m_gap = 0;
         if (plan.size() == 0) begin
            m_active = 0;
            m_done   = 1;
         end else begin
            model_issue();
         end
      end else begin
         model_issue();
      end
      if (push_ok) mq.push_back(pushed);
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   // Writes the bus takes at this edge (pre-edge DUT values).
   always @(posedge clk) begin
      if (rst === 1'b1 && bus.mem_wen && !bus.mem_stall) acc_q.push_back(bus.mem_wdata);
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      if (chk_en) begin
         chk("mem_wen",   {63'd0, bus.mem_wen},   {63'd0, m_wen});
         chk("mem_addr",  {34'd0, bus.mem_addr},  {34'd0, m_addr});
         chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, m_data});
         chk("busy",      {63'd0, busy},          {63'd0, m_active});
         chk("done",      {63'd0, done},          {63'd0, m_done});
         chk("sent_cnt",  {56'd0, sent_cnt},      64'(m_sent));
         chk("res_ready", {63'd0, bus.res_ready}, {63'd0, (mq.size() < DEPTH)});
         if (bus.mem_wen && first_wen_cyc < 0) first_wen_cyc = cyc;
         if (done && done_cyc < 0) done_cyc = cyc;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      bus.res_valid = 1'b0; bus.res_data = '0; bus.mem_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      acc_q.delete();
      first_wen_cyc = -1;
      done_cyc = -1;
   endtask

   task automatic push_word(input logic [31:0] w);
      @(negedge clk);
      bus.res_valid = 1'b1; bus.res_data = w;
      @(negedge clk);
      bus.res_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max);
      for (int i = 0; i < max; i++) begin
         if (done) break;
         @(negedge clk);
      end
      chk("wait_done", {63'd0, done}, 64'd1);
   endtask

   task automatic wait_wen_data(input logic [31:0] w, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (bus.mem_wen && bus.mem_wdata == w) break;
      end
      chk("wait_write", {63'd0, (bus.mem_wen && bus.mem_wdata == w)}, 64'd1);
   endtask

   initial begin
      int n;
      rst = 1'b0; start = 1'b0;
      bus.res_valid = 1'b0; bus.res_data = '0; bus.mem_stall = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      chk("reset_wen",   {63'd0, bus.mem_wen},   64'd0);
      chk("reset_ready", {63'd0, bus.res_ready}, 64'd1);
      chk("reset_sent",  {56'd0, sent_cnt},      64'd0);

      // 1: pre-filled frame, no stall
      do_reset();
      push_word(32'd479001600);
      push_word(32'd1);
      pulse_start();
      wait_done(50);
      chk("t1_count", 64'(acc_q.size()), 64'd4);
      if (acc_q.size() == 4) begin
         chk("t1_w0", {32'd0, acc_q[0]}, 64'h168);
         chk("t1_w1", {32'd0, acc_q[1]}, 64'd479001600);
         chk("t1_w2", {32'd0, acc_q[2]}, 64'd1);
         chk("t1_w3", {32'd0, acc_q[3]}, 64'hD5D);
      end
      chk("t1_latency", 64'(done_cyc - first_wen_cyc), 64'd8);

      // 2: three stall cycles on the first data write
      do_reset();
      push_word(32'h1111_1111);
      push_word(32'h2222_2222);
      pulse_start();
      wait_wen_data(32'h1111_1111, 20);
      n = 1;
      bus.mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.mem_wen && bus.mem_wdata == 32'h1111_1111) n++;
         chk("t2_sent_held", {56'd0, sent_cnt}, 64'd0);
         if (i == 2) bus.mem_stall = 1'b0;
      end
      chk("t2_hold_cycles", 64'(n), 64'd4);
      @(negedge clk);
      chk("t2_gap_wen", {63'd0, bus.mem_wen}, 64'd0);
      chk("t2_sent_one", {56'd0, sent_cnt}, 64'd1);
      wait_done(50);

      // 3: start with an empty FIFO
      do_reset();
      pulse_start();
      repeat (10) @(negedge clk);
      chk("t3_wait_wen", {63'd0, bus.mem_wen}, 64'd0);
      chk("t3_busy", {63'd0, busy}, 64'd1);
      chk("t3_begin_only", 64'(acc_q.size()), 64'd1);
      bus.res_valid = 1'b1; bus.res_data = 32'h0000_ABCD;
      @(negedge clk);
      bus.res_valid = 1'b0;
      chk("t3_not_yet", {63'd0, bus.mem_wen}, 64'd0);
      @(negedge clk);
      chk("t3_wen", {63'd0, bus.mem_wen}, 64'd1);
      chk("t3_data", {32'd0, bus.mem_wdata}, 64'hABCD);
      push_word(32'h0000_1234);
      wait_done(50);

      // 4: overfill without start, then drain one
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 4) chk("t4_full", {63'd0, bus.res_ready}, 64'd0);
         bus.res_valid = 1'b1; bus.res_data = 32'hA0 + 32'(i);
      end
      @(negedge clk);
      bus.res_valid = 1'b0;
      chk("t4_still_full", {63'd0, bus.res_ready}, 64'd0);
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         if (sent_cnt == 8'd1) break;
         @(negedge clk);
      end
      chk("t4_ready_after_pop", {63'd0, bus.res_ready}, 64'd1);
      wait_done(50);

      // 6: start in DONE takes the surplus words; mid-frame starts ignored
      acc_q.delete();
      chk("t6_done_held", {63'd0, done}, 64'd1);
      pulse_start();
      chk("t6_done_clr", {63'd0, done}, 64'd0);
      chk("t6_sent_clr", {56'd0, sent_cnt}, 64'd0);
      chk("t6_begin", {32'd0, bus.mem_wdata}, 64'h168);
      pulse_start();
      @(negedge clk);
      pulse_start();
      wait_done(50);
      chk("t6_count", 64'(acc_q.size()), 64'd4);
      if (acc_q.size() == 4) begin
         chk("t6_w1", {32'd0, acc_q[1]}, 64'hA2);
         chk("t6_w2", {32'd0, acc_q[2]}, 64'hA3);
      end

      // 5: reset during the second data write
      do_reset();
      push_word(32'h5555_0001);
      push_word(32'h5555_0002);
      pulse_start();
      wait_wen_data(32'h5555_0002, 20);
      #2 rst = 1'b0;
      #1;
      chk("t5_wen", {63'd0, bus.mem_wen}, 64'd0);
      chk("t5_busy", {63'd0, busy}, 64'd0);
      chk("t5_ready", {63'd0, bus.res_ready}, 64'd1);
      chk("t5_addr", {34'd0, bus.mem_addr}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      acc_q.delete();
      repeat (10) @(negedge clk);
      chk("t5_no_writes", 64'(acc_q.size()), 64'd0);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         bus.res_valid = ($urandom_range(0, 1) == 1);
         bus.res_data  = $urandom;
         bus.mem_stall = ($urandom_range(0, 3) == 0);
         start         = ($urandom_range(0, 19) == 0);
      end
      @(negedge clk);
      bus.res_valid = 1'b0; bus.mem_stall = 1'b0; start = 1'b0;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
